// File: rtl/axi4_arb_pkg.sv
// Shared types and helpers for the 2:1 AXI4 ID arbiter.
// The source index rides in the extra slave-side ID bit.
package axi4_arb_pkg;

    localparam int IN_ID_W  = 3;
    localparam int OUT_ID_W = IN_ID_W + 1;
    localparam int SRC_BIT  = IN_ID_W;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
    } ax_attr_t;

    typedef struct packed {
        logic       src;
        logic [IN_ID_W-1:0] id;
    } rsp_route_t;

    // Tie-break favours ptr; a lone requester always wins.
    function automatic logic rr_pick(
        input logic v0,
        input logic v1,
        input logic ptr
    );
        if (v0 && v1) begin
            return ptr;
        end
        return v1;
    endfunction

    function automatic ax_attr_t pack_attr(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic       lock,
        input logic [3:0] cache,
        input logic [2:0] prot,
        input logic [3:0] qos
    );
        ax_attr_t a;
        a.len   = len;
        a.size  = size;
        a.burst = burst;
        a.lock  = lock;
        a.cache = cache;
        a.prot  = prot;
        a.qos   = qos;
        return a;
    endfunction

endpackage

// File: rtl/axi4_wsel_fifo.sv
// Write-order FIFO of 1-bit source indices.
// The head names the master that currently owns the W channel.
module axi4_wsel_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi4_id_arbiter_2to1.sv
// Two AXI4 masters onto one slave; ID MSB carries the source index.
// Zero-latency muxing with locked round-robin grants on AR and AW.
module axi4_id_arbiter_2to1
    import axi4_arb_pkg::*;
#(
    parameter int ADDR_W   = 31,
    parameter int DATA_W   = 64,
    parameter int IN_ID_W  = axi4_arb_pkg::IN_ID_W,
    parameter int WQ_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in0_awvalid,
    output logic                in0_awready,
    input  logic [IN_ID_W-1:0]  in0_awid,
    input  logic [ADDR_W-1:0]   in0_awaddr,
    input  logic [7:0]          in0_awlen,
    input  logic [2:0]          in0_awsize,
    input  logic [1:0]          in0_awburst,
    input  logic                in0_awlock,
    input  logic [3:0]          in0_awcache,
    input  logic [2:0]          in0_awprot,
    input  logic [3:0]          in0_awqos,
    input  logic                in0_wvalid,
    output logic                in0_wready,
    input  logic [DATA_W-1:0]   in0_wdata,
    input  logic [DATA_W/8-1:0] in0_wstrb,
    input  logic                in0_wlast,
    output logic                in0_bvalid,
    input  logic                in0_bready,
    output logic [IN_ID_W-1:0]  in0_bid,
    input  logic                in0_arvalid,
    output logic                in0_arready,
    input  logic [IN_ID_W-1:0]  in0_arid,
    input  logic [ADDR_W-1:0]   in0_araddr,
    input  logic [7:0]          in0_arlen,
    input  logic [2:0]          in0_arsize,
    input  logic [1:0]          in0_arburst,
    input  logic                in0_arlock,
    input  logic [3:0]          in0_arcache,
    input  logic [2:0]          in0_arprot,
    input  logic [3:0]          in0_arqos,
    output logic                in0_rvalid,
    input  logic                in0_rready,
    output logic [IN_ID_W-1:0]  in0_rid,
    output logic [DATA_W-1:0]   in0_rdata,
    output logic                in0_rlast,
    input  logic                in1_awvalid,
    output logic                in1_awready,
    input  logic [IN_ID_W-1:0]  in1_awid,
    input  logic [ADDR_W-1:0]   in1_awaddr,
    input  logic [7:0]          in1_awlen,
    input  logic [2:0]          in1_awsize,
    input  logic [1:0]          in1_awburst,
    input  logic                in1_awlock,
    input  logic [3:0]          in1_awcache,
    input  logic [2:0]          in1_awprot,
    input  logic [3:0]          in1_awqos,
    input  logic                in1_wvalid,
    output logic                in1_wready,
    input  logic [DATA_W-1:0]   in1_wdata,
    input  logic [DATA_W/8-1:0] in1_wstrb,
    input  logic                in1_wlast,
    output logic                in1_bvalid,
    input  logic                in1_bready,
    output logic [IN_ID_W-1:0]  in1_bid,
    input  logic                in1_arvalid,
    output logic                in1_arready,
    input  logic [IN_ID_W-1:0]  in1_arid,
    input  logic [ADDR_W-1:0]   in1_araddr,
    input  logic [7:0]          in1_arlen,
    input  logic [2:0]          in1_arsize,
    input  logic [1:0]          in1_arburst,
    input  logic                in1_arlock,
    input  logic [3:0]          in1_arcache,
    input  logic [2:0]          in1_arprot,
    input  logic [3:0]          in1_arqos,
    output logic                in1_rvalid,
    input  logic                in1_rready,
    output logic [IN_ID_W-1:0]  in1_rid,
    output logic [DATA_W-1:0]   in1_rdata,
    output logic                in1_rlast,
    output logic                out_awvalid,
    input  logic                out_awready,
    output logic [IN_ID_W:0]    out_awid,
    output logic [ADDR_W-1:0]   out_awaddr,
    output logic [7:0]          out_awlen,
    output logic [2:0]          out_awsize,
    output logic [1:0]          out_awburst,
    output logic                out_awlock,
    output logic [3:0]          out_awcache,
    output logic [2:0]          out_awprot,
    output logic [3:0]          out_awqos,
    output logic                out_wvalid,
    input  logic                out_wready,
    output logic [DATA_W-1:0]   out_wdata,
    output logic [DATA_W/8-1:0] out_wstrb,
    output logic                out_wlast,
    input  logic                out_bvalid,
    output logic                out_bready,
    input  logic [IN_ID_W:0]    out_bid,
    output logic                out_arvalid,
    input  logic                out_arready,
    output logic [IN_ID_W:0]    out_arid,
    output logic [ADDR_W-1:0]   out_araddr,
    output logic [7:0]          out_arlen,
    output logic [2:0]          out_arsize,
    output logic [1:0]          out_arburst,
    output logic                out_arlock,
    output logic [3:0]          out_arcache,
    output logic [2:0]          out_arprot,
    output logic [3:0]          out_arqos,
    input  logic                out_rvalid,
    output logic                out_rready,
    input  logic [IN_ID_W:0]    out_rid,
    input  logic [DATA_W-1:0]   out_rdata,
    input  logic                out_rlast
);

    localparam int SRC = IN_ID_W;

    logic     ar_ptr, ar_lock, ar_lock_src, ar_src, ar_req;
    logic     aw_ptr, aw_lock, aw_lock_src, aw_src, aw_req;
    logic     wq_full, wq_empty, wq_head, wq_push, wq_pop;
    logic     b_src, r_src;
    ax_attr_t ar_attr0, ar_attr1, aw_attr0, aw_attr1;

    // ---------------- AR ----------------
    assign ar_attr0 = pack_attr(in0_arlen, in0_arsize, in0_arburst,
                                in0_arlock, in0_arcache, in0_arprot,
                                in0_arqos);
    assign ar_attr1 = pack_attr(in1_arlen, in1_arsize, in1_arburst,
                                in1_arlock, in1_arcache, in1_arprot,
                                in1_arqos);

    assign ar_src = ar_lock ? ar_lock_src
                            : rr_pick(in0_arvalid, in1_arvalid, ar_ptr);
    assign ar_req = ar_src ? in1_arvalid : in0_arvalid;

    assign out_arvalid = !reset && ar_req;
    assign in0_arready = !reset && !ar_src && out_arready;
    assign in1_arready = !reset && ar_src && out_arready;
    assign out_arid    = {ar_src, ar_src ? in1_arid : in0_arid};
    assign out_araddr  = ar_src ? in1_araddr : in0_araddr;
    assign {out_arlen, out_arsize, out_arburst, out_arlock,
            out_arcache, out_arprot, out_arqos} =
           ar_src ? ar_attr1 : ar_attr0;

    // ---------------- AW ----------------
    assign aw_attr0 = pack_attr(in0_awlen, in0_awsize, in0_awburst,
                                in0_awlock, in0_awcache, in0_awprot,
                                in0_awqos);
    assign aw_attr1 = pack_attr(in1_awlen, in1_awsize, in1_awburst,
                                in1_awlock, in1_awcache, in1_awprot,
                                in1_awqos);

    assign aw_src = aw_lock ? aw_lock_src
                            : rr_pick(in0_awvalid, in1_awvalid, aw_ptr);
    assign aw_req = aw_src ? in1_awvalid : in0_awvalid;

    // A full write-order FIFO must also hide ready from the master.
    assign out_awvalid = !reset && aw_req && !wq_full;
    assign in0_awready = !reset && !aw_src && !wq_full && out_awready;
    assign in1_awready = !reset && aw_src && !wq_full && out_awready;
    assign out_awid    = {aw_src, aw_src ? in1_awid : in0_awid};
    assign out_awaddr  = aw_src ? in1_awaddr : in0_awaddr;
    assign {out_awlen, out_awsize, out_awburst, out_awlock,
            out_awcache, out_awprot, out_awqos} =
           aw_src ? aw_attr1 : aw_attr0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ar_ptr      <= 1'b0;
            ar_lock     <= 1'b0;
            ar_lock_src <= 1'b0;
            aw_ptr      <= 1'b0;
            aw_lock     <= 1'b0;
            aw_lock_src <= 1'b0;
        end else begin
            ar_lock     <= out_arvalid && !out_arready;
            ar_lock_src <= ar_src;
            if (out_arvalid && out_arready) begin
                ar_ptr <= !ar_src;
            end
            aw_lock     <= out_awvalid && !out_awready;
            aw_lock_src <= aw_src;
            if (out_awvalid && out_awready) begin
                aw_ptr <= !aw_src;
            end
        end
    end

    // ---------------- W ----------------
    assign wq_push = out_awvalid && out_awready;
    assign wq_pop  = out_wvalid && out_wready && out_wlast;

    axi4_wsel_fifo #(
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clock (clock),
        .reset (reset),
        .push  (wq_push),
        .din   (aw_src),
        .pop   (wq_pop),
        .full  (wq_full),
        .empty (wq_empty),
        .head  (wq_head)
    );

    assign out_wvalid = !reset && !wq_empty &&
                        (wq_head ? in1_wvalid : in0_wvalid);
    assign in0_wready = !reset && !wq_empty && !wq_head && out_wready;
    assign in1_wready = !reset && !wq_empty && wq_head && out_wready;
    assign out_wdata  = wq_head ? in1_wdata : in0_wdata;
    assign out_wstrb  = wq_head ? in1_wstrb : in0_wstrb;
    assign out_wlast  = wq_head ? in1_wlast : in0_wlast;

    // ---------------- B / R ----------------
    assign b_src = out_bid[SRC];
    assign r_src = out_rid[SRC];

    assign in0_bvalid = !reset && out_bvalid && !b_src;
    assign in1_bvalid = !reset && out_bvalid && b_src;
    assign in0_bid    = out_bid[SRC-1:0];
    assign in1_bid    = out_bid[SRC-1:0];
    assign out_bready = !reset && (b_src ? in1_bready : in0_bready);

    assign in0_rvalid = !reset && out_rvalid && !r_src;
    assign in1_rvalid = !reset && out_rvalid && r_src;
    assign in0_rid    = out_rid[SRC-1:0];
    assign in1_rid    = out_rid[SRC-1:0];
    assign in0_rdata  = out_rdata;
    assign in1_rdata  = out_rdata;
    assign in0_rlast  = out_rlast;
    assign in1_rlast  = out_rlast;
    assign out_rready = !reset && (r_src ? in1_rready : in0_rready);

endmodule

// File: tb/tb_axi4_id_arbiter_2to1.sv
// Directed bench for axi4_id_arbiter_2to1.
// Handshakes on AR/AW/W are scored against queued expectations.
module tb_axi4_id_arbiter_2to1;
    import axi4_arb_pkg::*;

    logic clock = 1'b0;
    logic reset;

    logic in0_awvalid, in0_awready, in0_awlock;
    logic [2:0] in0_awid, in0_awsize, in0_awprot;
    logic [30:0] in0_awaddr;
    logic [7:0] in0_awlen;
    logic [1:0] in0_awburst;
    logic [3:0] in0_awcache, in0_awqos;
    logic in0_wvalid, in0_wready, in0_wlast;
    logic [63:0] in0_wdata;
    logic [7:0] in0_wstrb;
    logic in0_bvalid, in0_bready;
    logic [2:0] in0_bid;
    logic in0_arvalid, in0_arready, in0_arlock;
    logic [2:0] in0_arid, in0_arsize, in0_arprot;
    logic [30:0] in0_araddr;
    logic [7:0] in0_arlen;
    logic [1:0] in0_arburst;
    logic [3:0] in0_arcache, in0_arqos;
    logic in0_rvalid, in0_rready, in0_rlast;
    logic [2:0] in0_rid;
    logic [63:0] in0_rdata;

    logic in1_awvalid, in1_awready, in1_awlock;
    logic [2:0] in1_awid, in1_awsize, in1_awprot;
    logic [30:0] in1_awaddr;
    logic [7:0] in1_awlen;
    logic [1:0] in1_awburst;
    logic [3:0] in1_awcache, in1_awqos;
    logic in1_wvalid, in1_wready, in1_wlast;
    logic [63:0] in1_wdata;
    logic [7:0] in1_wstrb;
    logic in1_bvalid, in1_bready;
    logic [2:0] in1_bid;
    logic in1_arvalid, in1_arready, in1_arlock;
    logic [2:0] in1_arid, in1_arsize, in1_arprot;
    logic [30:0] in1_araddr;
    logic [7:0] in1_arlen;
    logic [1:0] in1_arburst;
    logic [3:0] in1_arcache, in1_arqos;
    logic in1_rvalid, in1_rready, in1_rlast;
    logic [2:0] in1_rid;
    logic [63:0] in1_rdata;

    logic out_awvalid, out_awready, out_awlock;
    logic [OUT_ID_W-1:0] out_awid;
    logic [30:0] out_awaddr;
    logic [7:0] out_awlen;
    logic [2:0] out_awsize, out_awprot;
    logic [1:0] out_awburst;
    logic [3:0] out_awcache, out_awqos;
    logic out_wvalid, out_wready, out_wlast;
    logic [63:0] out_wdata;
    logic [7:0] out_wstrb;
    logic out_bvalid, out_bready;
    logic [OUT_ID_W-1:0] out_bid;
    logic out_arvalid, out_arready, out_arlock;
    logic [OUT_ID_W-1:0] out_arid;
    logic [30:0] out_araddr;
    logic [7:0] out_arlen;
    logic [2:0] out_arsize, out_arprot;
    logic [1:0] out_arburst;
    logic [3:0] out_arcache, out_arqos;
    logic out_rvalid, out_rready, out_rlast;
    logic [OUT_ID_W-1:0] out_rid;
    logic [63:0] out_rdata;

    axi4_id_arbiter_2to1 dut (
        .clock(clock), .reset(reset),
        .in0_awvalid(in0_awvalid), .in0_awready(in0_awready),
        .in0_awid(in0_awid), .in0_awaddr(in0_awaddr),
        .in0_awlen(in0_awlen), .in0_awsize(in0_awsize),
        .in0_awburst(in0_awburst), .in0_awlock(in0_awlock),
        .in0_awcache(in0_awcache), .in0_awprot(in0_awprot),
        .in0_awqos(in0_awqos),
        .in0_wvalid(in0_wvalid), .in0_wready(in0_wready),
        .in0_wdata(in0_wdata), .in0_wstrb(in0_wstrb),
        .in0_wlast(in0_wlast),
        .in0_bvalid(in0_bvalid), .in0_bready(in0_bready),
        .in0_bid(in0_bid),
        .in0_arvalid(in0_arvalid), .in0_arready(in0_arready),
        .in0_arid(in0_arid), .in0_araddr(in0_araddr),
        .in0_arlen(in0_arlen), .in0_arsize(in0_arsize),
        .in0_arburst(in0_arburst), .in0_arlock(in0_arlock),
        .in0_arcache(in0_arcache), .in0_arprot(in0_arprot),
        .in0_arqos(in0_arqos),
        .in0_rvalid(in0_rvalid), .in0_rready(in0_rready),
        .in0_rid(in0_rid), .in0_rdata(in0_rdata),
        .in0_rlast(in0_rlast),
        .in1_awvalid(in1_awvalid), .in1_awready(in1_awready),
        .in1_awid(in1_awid), .in1_awaddr(in1_awaddr),
        .in1_awlen(in1_awlen), .in1_awsize(in1_awsize),
        .in1_awburst(in1_awburst), .in1_awlock(in1_awlock),
        .in1_awcache(in1_awcache), .in1_awprot(in1_awprot),
        .in1_awqos(in1_awqos),
        .in1_wvalid(in1_wvalid), .in1_wready(in1_wready),
        .in1_wdata(in1_wdata), .in1_wstrb(in1_wstrb),
        .in1_wlast(in1_wlast),
        .in1_bvalid(in1_bvalid), .in1_bready(in1_bready),
        .in1_bid(in1_bid),
        .in1_arvalid(in1_arvalid), .in1_arready(in1_arready),
        .in1_arid(in1_arid), .in1_araddr(in1_araddr),
        .in1_arlen(in1_arlen), .in1_arsize(in1_arsize),
        .in1_arburst(in1_arburst), .in1_arlock(in1_arlock),
        .in1_arcache(in1_arcache), .in1_arprot(in1_arprot),
        .in1_arqos(in1_arqos),
        .in1_rvalid(in1_rvalid), .in1_rready(in1_rready),
        .in1_rid(in1_rid), .in1_rdata(in1_rdata),
        .in1_rlast(in1_rlast),
        .out_awvalid(out_awvalid), .out_awready(out_awready),
        .out_awid(out_awid), .out_awaddr(out_awaddr),
        .out_awlen(out_awlen), .out_awsize(out_awsize),
        .out_awburst(out_awburst), .out_awlock(out_awlock),
        .out_awcache(out_awcache), .out_awprot(out_awprot),
        .out_awqos(out_awqos),
        .out_wvalid(out_wvalid), .out_wready(out_wready),
        .out_wdata(out_wdata), .out_wstrb(out_wstrb),
        .out_wlast(out_wlast),
        .out_bvalid(out_bvalid), .out_bready(out_bready),
        .out_bid(out_bid),
        .out_arvalid(out_arvalid), .out_arready(out_arready),
        .out_arid(out_arid), .out_araddr(out_araddr),
        .out_arlen(out_arlen), .out_arsize(out_arsize),
        .out_arburst(out_arburst), .out_arlock(out_arlock),
        .out_arcache(out_arcache), .out_arprot(out_arprot),
        .out_arqos(out_arqos),
        .out_rvalid(out_rvalid), .out_rready(out_rready),
        .out_rid(out_rid), .out_rdata(out_rdata),
        .out_rlast(out_rlast)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [OUT_ID_W-1:0] id;
        logic [30:0]         addr;
        logic [7:0]          len;
    } ax_exp_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } w_exp_t;

    ax_exp_t ar_q[$];
    ax_exp_t aw_q[$];
    w_exp_t  w_q[$];
    ax_exp_t mon_ax;
    w_exp_t  mon_w;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_outvalid"},
              64'({out_awvalid, out_wvalid, out_arvalid}), 64'(0));
        check({tag, "_inready"},
              64'({in0_awready, in1_awready, in0_wready, in1_wready,
                   in0_arready, in1_arready}), 64'(0));
        check({tag, "_resp"},
              64'({in0_bvalid, in1_bvalid, in0_rvalid, in1_rvalid,
                   out_bready, out_rready}), 64'(0));
    endtask

    // Scoreboard: every slave-side handshake must match the queue head.
    always @(negedge clock) begin
        if (out_arvalid && out_arready) begin
            check("ar_pending", 64'(ar_q.size() != 0), 64'(1));
            if (ar_q.size() != 0) begin
                mon_ax = ar_q.pop_front();
                check("ar_id", 64'(out_arid), 64'(mon_ax.id));
                check("ar_addr", 64'(out_araddr), 64'(mon_ax.addr));
                check("ar_len", 64'(out_arlen), 64'(mon_ax.len));
            end
        end
        if (out_awvalid && out_awready) begin
            check("aw_pending", 64'(aw_q.size() != 0), 64'(1));
            if (aw_q.size() != 0) begin
                mon_ax = aw_q.pop_front();
                check("aw_id", 64'(out_awid), 64'(mon_ax.id));
                check("aw_addr", 64'(out_awaddr), 64'(mon_ax.addr));
                check("aw_len", 64'(out_awlen), 64'(mon_ax.len));
            end
        end
        if (out_wvalid && out_wready) begin
            check("w_pending", 64'(w_q.size() != 0), 64'(1));
            if (w_q.size() != 0) begin
                mon_w = w_q.pop_front();
                check("w_data", out_wdata, mon_w.data);
                check("w_last", 64'(out_wlast), 64'(mon_w.last));
            end
        end
    end

    initial begin
        reset = 1'b1;
        in0_awid = '0; in0_awaddr = '0; in0_awlen = '0;
        in0_awsize = 3'd3; in0_awburst = 2'b01; in0_awlock = 1'b0;
        in0_awcache = '0; in0_awprot = '0; in0_awqos = '0;
        in1_awid = '0; in1_awaddr = '0; in1_awlen = '0;
        in1_awsize = 3'd3; in1_awburst = 2'b01; in1_awlock = 1'b0;
        in1_awcache = '0; in1_awprot = '0; in1_awqos = '0;
        in0_arid = '0; in0_araddr = '0; in0_arlen = '0;
        in0_arsize = 3'd3; in0_arburst = 2'b01; in0_arlock = 1'b0;
        in0_arcache = '0; in0_arprot = '0; in0_arqos = '0;
        in1_arid = '0; in1_araddr = '0; in1_arlen = '0;
        in1_arsize = 3'd3; in1_arburst = 2'b01; in1_arlock = 1'b0;
        in1_arcache = '0; in1_arprot = '0; in1_arqos = '0;
        in0_wdata = '0; in0_wstrb = '1; in0_wlast = 1'b0;
        in1_wdata = '0; in1_wstrb = '1; in1_wlast = 1'b0;
        out_bid = '0; out_rid = '0; out_rdata = '0; out_rlast = 1'b0;
        // everything requesting while reset is held
        in0_awvalid = 1'b1; in1_awvalid = 1'b1;
        in0_arvalid = 1'b1; in1_arvalid = 1'b1;
        in0_wvalid = 1'b1; in1_wvalid = 1'b1;
        in0_bready = 1'b1; in1_bready = 1'b1;
        in0_rready = 1'b1; in1_rready = 1'b1;
        out_awready = 1'b1; out_arready = 1'b1; out_wready = 1'b1;
        out_bvalid = 1'b1; out_rvalid = 1'b1;
        mid();
        idle_check("rst");
        in0_awvalid = 1'b0; in1_awvalid = 1'b0;
        in0_arvalid = 1'b0; in1_arvalid = 1'b0;
        in0_wvalid = 1'b0; in1_wvalid = 1'b0;
        in0_bready = 1'b0; in1_bready = 1'b0;
        in0_rready = 1'b0; in1_rready = 1'b0;
        out_awready = 1'b0; out_wready = 1'b0;
        out_bvalid = 1'b0; out_rvalid = 1'b0;
        tick();
        reset = 1'b0;

        // AR round-robin right after reset
        in0_arvalid = 1'b1; in0_arid = 3'd3; in0_araddr = 31'h100;
        in1_arvalid = 1'b1; in1_arid = 3'd5; in1_araddr = 31'h200;
        in1_arlen = 8'd1;
        out_arready = 1'b1;
        ar_q.push_back('{4'b0011, 31'h100, 8'd0});
        ar_q.push_back('{4'b1101, 31'h200, 8'd1});
        mid();
        check("t1_in0_arready", 64'(in0_arready), 64'(1));
        check("t1_in1_arready", 64'(in1_arready), 64'(0));
        tick();
        in0_arvalid = 1'b0;
        mid();
        check("t1_in1_arready_2", 64'(in1_arready), 64'(1));
        tick();
        in1_arvalid = 1'b0;

        // move the AR pointer to favour in1
        in0_arvalid = 1'b1; in0_arid = 3'd1; in0_araddr = 31'h300;
        ar_q.push_back('{4'b0001, 31'h300, 8'd0});
        mid();
        tick();

        // grant lock holds in0 while the slave stalls
        in0_arid = 3'd2; in0_araddr = 31'h400;
        out_arready = 1'b0;
        ar_q.push_back('{4'b0010, 31'h400, 8'd0});
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                in1_arvalid = 1'b1; in1_arid = 3'd6;
                in1_araddr = 31'h500; in1_arlen = 8'd0;
                ar_q.push_back('{4'b1110, 31'h500, 8'd0});
            end
            mid();
            check("t2_arid", 64'(out_arid), 64'(4'b0010));
            check("t2_araddr", 64'(out_araddr), 64'(31'h400));
            check("t2_in1_arready", 64'(in1_arready), 64'(0));
            tick();
        end
        out_arready = 1'b1;
        mid();
        check("t2_in0_arready", 64'(in0_arready), 64'(1));
        check("t2_in1_wait", 64'(in1_arready), 64'(0));
        tick();
        in0_arvalid = 1'b0;
        mid();
        check("t2_in1_arready_go", 64'(in1_arready), 64'(1));
        tick();
        in1_arvalid = 1'b0;
        out_arready = 1'b0;

        // response routing by the ID MSB
        out_rvalid = 1'b1; out_rid = 4'b1010; out_rlast = 1'b1;
        out_rdata = 64'hDEAD_BEEF_0123_4567;
        in1_rready = 1'b1; in0_rready = 1'b0;
        out_bvalid = 1'b1; out_bid = 4'b0101;
        in0_bready = 1'b1; in1_bready = 1'b0;
        mid();
        check("t3_in1_rvalid", 64'(in1_rvalid), 64'(1));
        check("t3_in1_rid", 64'(in1_rid), 64'(3'b010));
        check("t3_in0_rvalid", 64'(in0_rvalid), 64'(0));
        check("t3_out_rready", 64'(out_rready), 64'(1));
        check("t3_rdata", in1_rdata, 64'hDEAD_BEEF_0123_4567);
        check("t3_rdata0", in0_rdata, 64'hDEAD_BEEF_0123_4567);
        check("t3_rlast", 64'({in0_rlast, in1_rlast}), 64'(2'b11));
        check("t3_in0_bvalid", 64'(in0_bvalid), 64'(1));
        check("t3_in0_bid", 64'(in0_bid), 64'(3'b101));
        check("t3_in1_bvalid", 64'(in1_bvalid), 64'(0));
        check("t3_out_bready", 64'(out_bready), 64'(1));
        tick();
        in1_rready = 1'b0; in0_rready = 1'b1;
        in0_bready = 1'b0; in1_bready = 1'b1;
        mid();
        check("t3_out_rready_lo", 64'(out_rready), 64'(0));
        check("t3_out_bready_lo", 64'(out_bready), 64'(0));
        tick();
        out_rvalid = 1'b0; out_bvalid = 1'b0;
        in0_rready = 1'b0; in1_bready = 1'b0;

        // W follows AW order; in1's early W waits for in0's burst
        out_awready = 1'b1; out_wready = 1'b1;
        in0_awvalid = 1'b1; in0_awid = 3'd1; in0_awaddr = 31'h1000;
        in0_awlen = 8'd3;
        in1_awvalid = 1'b1; in1_awid = 3'd4; in1_awaddr = 31'h2000;
        in1_awlen = 8'd0;
        in1_wvalid = 1'b1; in1_wdata = 64'h1111; in1_wlast = 1'b1;
        aw_q.push_back('{4'b0001, 31'h1000, 8'd3});
        aw_q.push_back('{4'b1100, 31'h2000, 8'd0});
        for (int k = 0; k < 4; k++) begin
            w_q.push_back('{64'hA0 + 64'(k), k == 3});
        end
        w_q.push_back('{64'h1111, 1'b1});
        mid();
        check("t4_w_before_aw", 64'(in1_wready), 64'(0));
        check("t4_out_wvalid", 64'(out_wvalid), 64'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) in0_awvalid = 1'b0;
            if (k == 1) in1_awvalid = 1'b0;
            in0_wvalid = 1'b1;
            in0_wdata = 64'hA0 + 64'(k);
            in0_wlast = (k == 3);
            mid();
            check("t4_in1_wready_hold", 64'(in1_wready), 64'(0));
        end
        tick();
        in0_wvalid = 1'b0; in0_wlast = 1'b0;
        mid();
        check("t4_in1_wready", 64'(in1_wready), 64'(1));
        check("t4_in0_wready", 64'(in0_wready), 64'(0));
        tick();
        in1_wvalid = 1'b0; in1_wlast = 1'b0;

        // fill the write-order FIFO, then free one slot
        in0_awvalid = 1'b1; in0_awid = 3'd7; in0_awaddr = 31'h3000;
        in0_awlen = 8'd0;
        for (int i = 0; i < 5; i++) begin
            aw_q.push_back('{4'b0111, 31'h3000, 8'd0});
        end
        for (int i = 0; i < 4; i++) begin
            mid();
            check("t5_fill_ready", 64'(in0_awready), 64'(1));
            tick();
        end
        mid();
        check("t5_full_awvalid", 64'(out_awvalid), 64'(0));
        check("t5_full_awready", 64'(in0_awready), 64'(0));
        tick();
        in0_wvalid = 1'b1; in0_wdata = 64'h5555; in0_wlast = 1'b1;
        w_q.push_back('{64'h5555, 1'b1});
        mid();
        check("t5_no_bypass", 64'(out_awvalid), 64'(0));
        tick();
        in0_wvalid = 1'b0; in0_wlast = 1'b0;
        mid();
        check("t5_after_pop", 64'(out_awvalid), 64'(1));
        tick();
        in0_awvalid = 1'b0;

        // reset in the middle of a W burst
        in0_awvalid = 1'b1; in1_awvalid = 1'b1;
        in0_awid = 3'd2; in0_awaddr = 31'h7000; in0_awlen = 8'd1;
        in0_wvalid = 1'b1; in0_wdata = 64'h6001; in0_wlast = 1'b0;
        w_q.push_back('{64'h6001, 1'b0});
        mid();
        tick();
        in0_wdata = 64'h6002;
        w_q.push_back('{64'h6002, 1'b0});
        out_bvalid = 1'b1; out_rvalid = 1'b1;
        in0_bready = 1'b1; in0_rready = 1'b1;
        out_arready = 1'b1;
        mid();
        #2;
        reset = 1'b1;
        #1;
        idle_check("t6_rst");
        tick();
        tick();
        reset = 1'b0;
        out_bvalid = 1'b0; out_rvalid = 1'b0;
        in0_bready = 1'b0; in0_rready = 1'b0;
        out_arready = 1'b0;
        aw_q.push_back('{4'b0010, 31'h7000, 8'd1});
        mid();
        check("t6_in0_awready", 64'(in0_awready), 64'(1));
        check("t6_in1_awready", 64'(in1_awready), 64'(0));
        check("t6_wq_empty", 64'(out_wvalid), 64'(0));
        tick();
        in0_awvalid = 1'b0; in1_awvalid = 1'b0; in0_wvalid = 1'b0;
        mid();

        check("ar_q_drained", 64'(ar_q.size()), 64'(0));
        check("aw_q_drained", 64'(aw_q.size()), 64'(0));
        check("w_q_drained", 64'(w_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
